addsub_arbiter: RTL

Shares one WIDTH-bit adder/subtractor between two requesters. Each requester presents operands and an add/subtract select under a valid/ready handshake. A round-robin arbiter grants one request at a time, and a three-state FSM sequences the operation through the shared datapath. The registered result (sum, carry-out, requester ID) is returned on a single response channel with its own valid/ready handshake. The block sits between lab-level operand sources and the add/subtract datapath.

---
 rtl/addsub_arbiter_pkg.sv | 30 +++
 rtl/addsub_core.sv | 58 +++++
 rtl/addsub_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// addsub_arbiter_pkg
//
// Purpose:
//     Shared constants for the two-requester add/subtract arbiter: the FSM
//     state encodings, the default operand width and the add/subtract select
//     encodings used by both the arbiter and the shared datapath.
//
// Contents:
//     DEFAULT_WIDTH   default operand/result width
//     state_t         2-bit FSM state type
//     IDLE/EXEC/RESP  FSM state encodings
//     ADD/SUB         values of the per-request select bit
// -----------------------------------------------------------------------------
package addsub_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [1:0] state_t;

    // Encodings are fixed so that older tooling reading the state register
    // sees the same values.
    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// -----------------------------------------------------------------------------
// addsub_core
//
// Purpose:
//     Purely combinational WIDTH-bit adder/subtractor shared by both
//     requesters. Subtraction is formed as A + ~B + 1, so the carry-out reads
//     as "no borrow" when subtracting.
//
// Configuration:
//     ADDSUB_OVF_EN  when defined, adds the signed-overflow output ovf_o.
//
// Ports:
//     a_i     operand A
//     b_i     operand B
//     sel_i   0 = add, 1 = subtract (A - B)
//     s_o     result, modulo 2^WIDTH
//     cout_o  carry out of bit WIDTH-1
//     ovf_o   signed overflow (only with ADDSUB_OVF_EN)
// -----------------------------------------------------------------------------
module addsub_core
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o
`ifdef ADDSUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    logic [WIDTH-1:0] bEff;
    logic             carryIn;
    logic [WIDTH:0]   sumFull;

    // One extra bit on the sum captures the carry out of the top operand bit.
    always_comb begin
        bEff    = (sel_i == ADD) ? b_i : ~b_i;
        carryIn = (sel_i == SUB);
        sumFull = {1'b0, a_i} + {1'b0, bEff} + {{WIDTH{1'b0}}, carryIn};
    end

    assign s_o    = sumFull[WIDTH-1:0];
    assign cout_o = sumFull[WIDTH];

`ifdef ADDSUB_OVF_EN
    // Signed overflow: both effective operands share a sign and the result
    // sign differs from it. Using the inverted B for subtract makes this the
    // overflow of A - B.
    assign ovf_o = (a_i[WIDTH-1] == bEff[WIDTH-1]) &&
                   (sumFull[WIDTH-1] != a_i[WIDTH-1]);
`endif

endmodule

// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
//
// Purpose:
//     Shares one addsub_core between two requesters. A round-robin arbiter
//     picks one request in IDLE, the operands are latched, pushed through the
//     datapath in EXEC and the registered result is held in RESP until the
//     consumer takes it.
//
// Configuration:
//     ADDSUB_OVF_EN  when defined, the registered signed-overflow flag is
//                    returned on rsp_ovf.
//
// Ports:
//     clk, rst                  rising-edge clock, async active-high reset
//     reqN_valid/a/b/sel        requester N operation (N = 0, 1)
//     reqN_ready                requester N accepted this cycle
//     rsp_valid / rsp_ready     response handshake
//     rsp_id                    requester that issued the operation
//     rsp_s / rsp_cout          result and carry-out
//     rsp_ovf                   signed overflow (only with ADDSUB_OVF_EN)
// -----------------------------------------------------------------------------
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sel,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sel,
    output logic             req1_ready,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_cout
`ifdef ADDSUB_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);

    state_t           state_q, state_d;
    logic             lastServed_q, lastServed_d;

    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic             opSel_q, opSel_d;
    logic             opId_q, opId_d;

    logic [WIDTH-1:0] rspS_q, rspS_d;
    logic             rspCout_q, rspCout_d;
    logic             rspId_q, rspId_d;

    logic             grantId;
    logic             inIdle;
    logic             accept;

    logic [WIDTH-1:0] coreS;
    logic             coreCout;

`ifdef ADDSUB_OVF_EN
    logic             rspOvf_q, rspOvf_d;
    logic             coreOvf;
`endif

    // Round-robin grant: a lone valid requester always wins; on a tie the
    // requester that was not served last wins. Ready is forced low during
    // reset and outside IDLE so nothing is accepted while busy.
    always_comb begin
        grantId = 1'b0;
        if (req0_valid && req1_valid) begin
            grantId = ~lastServed_q;
        end else if (req1_valid) begin
            grantId = 1'b1;
        end

        inIdle     = (state_q == IDLE) && !rst;
        req0_ready = inIdle && req0_valid && (grantId == 1'b0);
        req1_ready = inIdle && req1_valid && (grantId == 1'b1);
        accept     = req0_ready || req1_ready;
    end

    // The shared datapath always sees the latched operands; its output is
    // only captured during EXEC.
    addsub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i    (opA_q),
        .b_i    (opB_q),
        .sel_i  (opSel_q),
        .s_o    (coreS),
        .cout_o (coreCout)
`ifdef ADDSUB_OVF_EN
        ,
        .ovf_o  (coreOvf)
`endif
    );

    // Next-state logic. The last-served pointer only moves when the response
    // is handed over, so a tie that arises while busy resolves against the
    // requester whose result was most recently delivered.
    always_comb begin
        state_d      = state_q;
        lastServed_d = lastServed_q;
        opA_d        = opA_q;
        opB_d        = opB_q;
        opSel_d      = opSel_q;
        opId_d       = opId_q;
        rspS_d       = rspS_q;
        rspCout_d    = rspCout_q;
        rspId_d      = rspId_q;
`ifdef ADDSUB_OVF_EN
        rspOvf_d     = rspOvf_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    opA_d   = grantId ? req1_a   : req0_a;
                    opB_d   = grantId ? req1_b   : req0_b;
                    opSel_d = grantId ? req1_sel : req0_sel;
                    opId_d  = grantId;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rspS_d    = coreS;
                rspCout_d = coreCout;
                rspId_d   = opId_q;
`ifdef ADDSUB_OVF_EN
                rspOvf_d  = coreOvf;
`endif
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    lastServed_d = rspId_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers. Reset leaves the pointer on requester 1 so
    // requester 0 wins the first tie, and drops any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lastServed_q <= 1'b1;
            opA_q        <= '0;
            opB_q        <= '0;
            opSel_q      <= ADD;
            opId_q       <= 1'b0;
            rspS_q       <= '0;
            rspCout_q    <= 1'b0;
            rspId_q      <= 1'b0;
`ifdef ADDSUB_OVF_EN
            rspOvf_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lastServed_q <= lastServed_d;
            opA_q        <= opA_d;
            opB_q        <= opB_d;
            opSel_q      <= opSel_d;
            opId_q       <= opId_d;
            rspS_q       <= rspS_d;
            rspCout_q    <= rspCout_d;
            rspId_q      <= rspId_d;
`ifdef ADDSUB_OVF_EN
            rspOvf_q     <= rspOvf_d;
`endif
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rspId_q;
    assign rsp_s     = rspS_q;
    assign rsp_cout  = rspCout_q;
`ifdef ADDSUB_OVF_EN
    assign rsp_ovf   = rspOvf_q;
`endif

endmodule
